// File: rtl/laby7_sumator.sv
// -----------------------------------------------------------------------------
// laby7_sumator
//
// Registered unsigned adder with a valid strobe. Two WIDTH-bit operands are
// summed at WIDTH+1 bits, so the carry-out is kept and the result never wraps
// or saturates. The sum appears exactly one clock after the operands are
// sampled with in_valid high. With in_valid low the previous sum is held and
// out_valid drops.
//
// Parameters
//   WIDTH      operand width in bits (>= 1); the result is WIDTH+1 bits wide
//
// Ports
//   clk        in   1        system clock, rising-edge active
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        a/b carry valid operands this cycle
//   a          in   WIDTH    operand A, unsigned
//   b          in   WIDTH    operand B, unsigned
//   y          out  WIDTH+1  registered sum a+b, unsigned
//   out_valid  out  1        y holds a freshly computed sum
// -----------------------------------------------------------------------------
module laby7_sumator #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   y,
    output logic             out_valid
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] y_d;
    logic [WIDTH:0] y_q;
    logic           valid_d;
    logic           valid_q;

    // Zero-extend both operands before adding so the carry lands in the top bit.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
    end

    // Next-state: load the sum on a valid cycle, otherwise hold y and drop valid.
    // a/b are ignored entirely while in_valid is low.
    always_comb begin
        y_d     = y_q;
        valid_d = 1'b0;
        if (in_valid) begin
            y_d     = sum_s;
            valid_d = 1'b1;
        end else begin
            y_d     = y_q;
            valid_d = 1'b0;
        end
    end

    // Result and strobe registers; reset clears both immediately and discards
    // any operands presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= {(WIDTH + 1){1'b0}};
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_laby7_sumator.sv
module tb_laby7_sumator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] y;
    logic       out_valid;

    logic       in_valid4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [4:0] y4;
    logic       out_valid4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] ey;
        logic       ev;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    laby7_sumator #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .y         (y),
        .out_valid (out_valid)
    );

    laby7_sumator #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .a         (a4),
        .b         (b4),
        .y         (y4),
        .out_valid (out_valid4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // vector table: exhaustive 2-bit sums, then a hold entry after 3+3
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                vec_t t;
                t.v  = 1'b1;
                t.a  = 2'(i);
                t.b  = 2'(j);
                t.ey = 3'(i + j);
                t.ev = 1'b1;
                vecs.push_back(t);
            end
        end
        begin
            vec_t t;
            t.v = 1'b0; t.a = 2'd1; t.b = 2'd0; t.ey = 3'd6; t.ev = 1'b0;
            vecs.push_back(t);
        end

        // reset held with live operands
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 2'd3;
        b         = 2'd3;
        in_valid4 = 1'b1;
        a4        = 4'd15;
        b4        = 4'd15;
        #1;
        chk("reset_y_t0", 32'(y), 32'd0);
        chk("reset_v_t0", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("reset_y_%0d", k), 32'(y), 32'd0);
            chk($sformatf("reset_v_%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("reset_y4_%0d", k), 32'(y4), 32'd0);
        end
        rst       = 1'b0;
        in_valid4 = 1'b0;

        // table-driven vectors; the first edge after reset must already sample
        for (int n = 0; n < vecs.size(); n++) begin
            in_valid = vecs[n].v;
            a        = vecs[n].a;
            b        = vecs[n].b;
            cyc();
            chk($sformatf("vec%0d_%0d+%0d_y", n, vecs[n].a, vecs[n].b), 32'(y), 32'(vecs[n].ey));
            chk($sformatf("vec%0d_valid", n), 32'(out_valid), 32'(vecs[n].ev));
        end

        // hold: 2+3 then random operands with in_valid low
        in_valid = 1'b1; a = 2'd2; b = 2'd3;
        cyc();
        chk("hold_load_y", 32'(y), 32'd5);
        chk("hold_load_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            cyc();
            chk($sformatf("hold_y_%0d", k), 32'(y), 32'd5);
            chk($sformatf("hold_v_%0d", k), 32'(out_valid), 32'd0);
        end

        // back-to-back
        in_valid = 1'b1; a = 2'd1; b = 2'd1;
        cyc();
        chk("b2b_1_y", 32'(y), 32'd2);
        chk("b2b_1_v", 32'(out_valid), 32'd1);
        a = 2'd3; b = 2'd2;
        cyc();
        chk("b2b_2_y", 32'(y), 32'd5);
        chk("b2b_2_v", 32'(out_valid), 32'd1);
        a = 2'd0; b = 2'd3;
        cyc();
        chk("b2b_3_y", 32'(y), 32'd3);
        chk("b2b_3_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        cyc();
        chk("b2b_end_y", 32'(y), 32'd3);
        chk("b2b_end_v", 32'(out_valid), 32'd0);

        // mid-operation reset: y=3 currently, 3+3 pending, rst pulsed mid-cycle
        in_valid = 1'b1; a = 2'd3; b = 2'd3;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_async_y", 32'(y), 32'd0);
        chk("midrst_async_v", 32'(out_valid), 32'd0);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("midrst_after_y", 32'(y), 32'd0);
        chk("midrst_after_v", 32'(out_valid), 32'd0);
        in_valid = 1'b1; a = 2'd1; b = 2'd2;
        cyc();
        chk("midrst_1+2_y", 32'(y), 32'd3);
        chk("midrst_1+2_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;

        // WIDTH=4 instance
        in_valid4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        cyc();
        chk("w4_15+15_y", 32'(y4), 32'd30);
        chk("w4_15+15_v", 32'(out_valid4), 32'd1);
        a4 = 4'd8; b4 = 4'd9;
        cyc();
        chk("w4_8+9_y", 32'(y4), 32'd17);
        in_valid4 = 1'b0; a4 = 4'd1; b4 = 4'd1;
        cyc();
        chk("w4_hold_y", 32'(y4), 32'd17);
        chk("w4_hold_v", 32'(out_valid4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
